// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master with clock divider, CPOL/CPHA modes,
// selectable bit order and NUM_SLAVES active-low chip selects.
`default_nettype none

module spi_master_param #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 3,
    parameter int CLK_DIV    = 2
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 start,
    input  logic [((NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1)-1:0] slaveSelect,
    input  logic                                                 cpol,
    input  logic                                                 cpha,
    input  logic                                                 lsb_first,
    input  logic [DATA_WIDTH-1:0]                                masterDataToSend,
    output logic [DATA_WIDTH-1:0]                                masterDataReceived,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 err,
    output logic                                                 SCLK,
    output logic [NUM_SLAVES-1:0]                                CS,
    output logic                                                 MOSI,
    input  logic                                                 MISO
);

    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [DIV_W-1:0]      DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0]     EDGE_LAST   = EDGE_W'(2 * DATA_WIDTH);
    localparam logic [SEL_W:0]        SLAVE_LIMIT = (SEL_W + 1)'(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0] CS_ONE      = NUM_SLAVES'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    state_t                state;
    logic [DIV_W-1:0]      div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  lat_cpol;
    logic                  lat_cpha;
    logic                  lat_lsb;

    logic [EDGE_W-1:0]     edge_next;
    logic                  div_wrap;
    logic                  sample_now;
    logic                  drive_now;
    logic                  tx_bit;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic [DATA_WIDTH-1:0] rx_shifted;
    logic                  load_bit;
    logic [DATA_WIDTH-1:0] load_rest;

    always_comb begin
        edge_next  = edge_cnt + EDGE_W'(1);
        div_wrap   = (div_cnt == DIV_LAST);
        // Odd edge numbers are leading edges; cpha picks which kind samples.
        sample_now = lat_cpha ? !edge_next[0] : edge_next[0];
        drive_now  = lat_cpha ? edge_next[0] : (!edge_next[0] && (edge_next != EDGE_LAST));
        tx_bit     = lat_lsb ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
        tx_shifted = lat_lsb ? (tx_sh >> 1) : (tx_sh << 1);
        rx_shifted = lat_lsb ? {MISO, rx_sh[DATA_WIDTH-1:1]} : {rx_sh[DATA_WIDTH-2:0], MISO};
        load_bit   = lsb_first ? masterDataToSend[0] : masterDataToSend[DATA_WIDTH-1];
        load_rest  = lsb_first ? (masterDataToSend >> 1) : (masterDataToSend << 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            div_cnt            <= '0;
            edge_cnt           <= '0;
            tx_sh              <= '0;
            rx_sh              <= '0;
            lat_cpol           <= 1'b0;
            lat_cpha           <= 1'b0;
            lat_lsb            <= 1'b0;
            masterDataReceived <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            SCLK               <= 1'b0;
            CS                 <= '1;
            MOSI               <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if ({1'b0, slaveSelect} < SLAVE_LIMIT) begin
                            state    <= LEAD;
                            busy     <= 1'b1;
                            CS       <= ~(CS_ONE << slaveSelect);
                            SCLK     <= cpol;
                            lat_cpol <= cpol;
                            lat_cpha <= cpha;
                            lat_lsb  <= lsb_first;
                            div_cnt  <= '0;
                            edge_cnt <= '0;
                            rx_sh    <= '0;
                            // With cpha=0 the first bit must be valid before the first edge.
                            if (!cpha) begin
                                MOSI  <= load_bit;
                                tx_sh <= load_rest;
                            end else begin
                                MOSI  <= 1'b0;
                                tx_sh <= masterDataToSend;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LEAD, XFER: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        edge_cnt <= edge_next;
                        SCLK     <= ~SCLK;
                        if (sample_now) begin
                            rx_sh <= rx_shifted;
                        end
                        if (drive_now) begin
                            MOSI  <= tx_bit;
                            tx_sh <= tx_shifted;
                        end
                        state <= (edge_next == EDGE_LAST) ? TRAIL : XFER;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                TRAIL: begin
                    if (div_wrap) begin
                        div_cnt            <= '0;
                        state              <= IDLE;
                        busy               <= 1'b0;
                        done               <= 1'b1;
                        CS                 <= '1;
                        MOSI               <= 1'b0;
                        SCLK               <= lat_cpol;
                        masterDataReceived <= rx_sh;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed checks of spi_master_param (W=8, 3 slaves, divider 2).
`default_nettype none

module tb_spi_master_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] slaveSelect;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [7:0] masterDataToSend;
    logic [7:0] masterDataReceived;
    logic       busy;
    logic       done;
    logic       err;
    logic       SCLK;
    logic [2:0] CS;
    logic       MOSI;
    logic       MISO;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model (mode 3, MSB-first); otherwise MISO loops back from MOSI.
    logic       slave_en = 1'b0;
    logic [7:0] slave_word = 8'h00;
    logic [7:0] slave_rx = 8'h00;
    logic [2:0] slave_bit = 3'd0;
    logic       slave_out = 1'b0;
    logic       sclk_q = 1'b0;
    logic       cs_q = 1'b0;

    assign MISO = slave_en ? slave_out : MOSI;

    spi_master_param #(
        .DATA_WIDTH(8),
        .NUM_SLAVES(3),
        .CLK_DIV   (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .slaveSelect       (slaveSelect),
        .cpol              (cpol),
        .cpha              (cpha),
        .lsb_first         (lsb_first),
        .masterDataToSend  (masterDataToSend),
        .masterDataReceived(masterDataReceived),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .SCLK              (SCLK),
        .CS                (CS),
        .MOSI              (MOSI),
        .MISO              (MISO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sclk_q <= SCLK;
        cs_q   <= (CS != 3'b111);
        if (CS == 3'b111) begin
            slave_bit <= 3'd0;
        end else if (cs_q) begin
            if (sclk_q && !SCLK) begin
                slave_out <= slave_word[~slave_bit];
                slave_bit <= slave_bit + 3'd1;
            end
            if (!sclk_q && SCLK) begin
                slave_rx <= {slave_rx[6:0], MOSI};
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observations of the most recent transfer.
    int         r_done_cyc;
    int         r_rise_cnt;
    int         r_first_rise;
    int         r_cs_bad;
    int         r_busy_bad;
    int         r_mosi_bad;
    logic [2:0] r_cs_c1;
    logic       r_busy_c1;
    logic       r_sclk_c1;
    logic       r_sclk_end;
    logic       r_mosi_end;
    logic       r_busy_end;
    logic [2:0] r_cs_end;
    logic [7:0] r_rx;
    logic [7:0] r_stream;

    task automatic do_xfer(input logic pol, input logic pha, input logic lsb,
                           input logic [7:0] tx, input logic [1:0] sel);
        logic       prev_sclk;
        logic       prev_mosi;
        logic       smp;
        logic [2:0] one;
        logic [2:0] exp_cs;
        int         k;
        one    = 3'b001;
        exp_cs = ~(one << sel);
        @(negedge clk);
        cpol = pol; cpha = pha; lsb_first = lsb;
        masterDataToSend = tx; slaveSelect = sel; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        r_done_cyc = 0; r_rise_cnt = 0; r_first_rise = 0;
        r_cs_bad = 0; r_busy_bad = 0; r_mosi_bad = 0; r_stream = 8'h00;
        k = 0; prev_sclk = 1'b0; prev_mosi = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done) begin
                r_done_cyc = c;
                r_rx       = masterDataReceived;
                r_sclk_end = SCLK;
                r_mosi_end = MOSI;
                r_busy_end = busy;
                r_cs_end   = CS;
                break;
            end
            if (CS != exp_cs) r_cs_bad++;
            if (!busy) r_busy_bad++;
            if (c == 1) begin
                r_cs_c1   = CS;
                r_busy_c1 = busy;
                r_sclk_c1 = SCLK;
            end else begin
                smp = 1'b0;
                if (SCLK != prev_sclk) begin
                    k++;
                    if (SCLK) begin
                        r_rise_cnt++;
                        if (r_first_rise == 0) r_first_rise = c;
                    end
                    smp = pha ? (k % 2 == 0) : (k % 2 == 1);
                    if (smp) begin
                        r_stream = lsb ? {prev_mosi, r_stream[7:1]} : {r_stream[6:0], prev_mosi};
                    end
                end
                if ((MOSI != prev_mosi) && ((SCLK == prev_sclk) || smp)) r_mosi_bad++;
            end
            prev_sclk = SCLK;
            prev_mosi = MOSI;
        end
    endtask

    int         d1;
    int         d2;
    int         ndone;
    int         nbusy;
    logic [2:0] cs_d1;
    logic [2:0] cs_after;
    logic       busy_after;

    initial begin
        reset = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        masterDataToSend = 8'h00; slaveSelect = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cs", 32'(CS), 32'h7);
        check_eq("rst_sclk", 32'(SCLK), 32'h0);
        check_eq("rst_mosi", 32'(MOSI), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_rx", 32'(masterDataReceived), 32'h0);
        reset = 1'b0;

        // Mode 0, LSB first, loopback, slave 1.
        do_xfer(1'b0, 1'b0, 1'b1, 8'hA5, 2'd1);
        check_eq("m0_done_cyc", 32'(r_done_cyc), 32'd35);
        check_eq("m0_rises", 32'(r_rise_cnt), 32'd8);
        check_eq("m0_first_rise", 32'(r_first_rise), 32'd3);
        check_eq("m0_cs_c1", 32'(r_cs_c1), 32'h5);
        check_eq("m0_busy_c1", 32'(r_busy_c1), 32'h1);
        check_eq("m0_cs_bad", 32'(r_cs_bad), 32'd0);
        check_eq("m0_busy_bad", 32'(r_busy_bad), 32'd0);
        check_eq("m0_mosi_bad", 32'(r_mosi_bad), 32'd0);
        check_eq("m0_stream", 32'(r_stream), 32'hA5);
        check_eq("m0_rx", 32'(r_rx), 32'hA5);
        check_eq("m0_cs_end", 32'(r_cs_end), 32'h7);
        check_eq("m0_busy_end", 32'(r_busy_end), 32'h0);
        check_eq("m0_mosi_end", 32'(r_mosi_end), 32'h0);
        @(negedge clk);
        check_eq("m0_done_pulse", 32'(done), 32'h0);
        check_eq("m0_rx_hold", 32'(masterDataReceived), 32'hA5);

        // Mode 3, MSB first, against the slave model.
        slave_en = 1'b1; slave_word = 8'h3C;
        do_xfer(1'b1, 1'b1, 1'b0, 8'h81, 2'd0);
        check_eq("m3_sclk_c1", 32'(r_sclk_c1), 32'h1);
        check_eq("m3_done_cyc", 32'(r_done_cyc), 32'd35);
        check_eq("m3_rx", 32'(r_rx), 32'h3C);
        check_eq("m3_slave_rx", 32'(slave_rx), 32'h81);
        check_eq("m3_sclk_end", 32'(r_sclk_end), 32'h1);
        check_eq("m3_mosi_bad", 32'(r_mosi_bad), 32'd0);
        check_eq("m3_cs_bad", 32'(r_cs_bad), 32'd0);

        // Mode 3, LSB first: bit order seen by an MSB-first slave.
        slave_word = 8'hC5;
        do_xfer(1'b1, 1'b1, 1'b1, 8'h12, 2'd2);
        check_eq("m3l_rx", 32'(r_rx), 32'hA3);
        check_eq("m3l_slave_rx", 32'(slave_rx), 32'h48);
        slave_en = 1'b0;

        do_xfer(1'b0, 1'b1, 1'b1, 8'h5A, 2'd0);
        check_eq("m1_rx", 32'(r_rx), 32'h5A);
        check_eq("m1_mosi_bad", 32'(r_mosi_bad), 32'd0);
        check_eq("m1_sclk_end", 32'(r_sclk_end), 32'h0);

        do_xfer(1'b1, 1'b0, 1'b0, 8'h5A, 2'd2);
        check_eq("m2_rx", 32'(r_rx), 32'h5A);
        check_eq("m2_mosi_bad", 32'(r_mosi_bad), 32'd0);
        check_eq("m2_sclk_end", 32'(r_sclk_end), 32'h1);
        check_eq("m2_cs_bad", 32'(r_cs_bad), 32'd0);

        do_xfer(1'b0, 1'b0, 1'b0, 8'h1E, 2'd0);
        check_eq("m0m_stream", 32'(r_stream), 32'h1E);
        check_eq("m0m_rx", 32'(r_rx), 32'h1E);
        do_xfer(1'b0, 1'b1, 1'b1, 8'h1E, 2'd1);
        check_eq("m1l_stream", 32'(r_stream), 32'h1E);
        check_eq("m1l_rx", 32'(r_rx), 32'h1E);

        // Out-of-range slave select.
        @(negedge clk);
        slaveSelect = 2'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("err_pulse", 32'(err), 32'h1);
        check_eq("err_cs", 32'(CS), 32'h7);
        check_eq("err_busy", 32'(busy), 32'h0);
        ndone = 0; nbusy = 0;
        @(negedge clk);
        check_eq("err_clear", 32'(err), 32'h0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy || (CS != 3'b111)) nbusy++;
        end
        check_eq("err_no_done", 32'(ndone), 32'd0);
        check_eq("err_no_busy", 32'(nbusy), 32'd0);

        // start held high across two transfers.
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b1;
        masterDataToSend = 8'h33; slaveSelect = 2'd0; start = 1'b1;
        @(posedge clk);
        d1 = 0; d2 = 0; ndone = 0; cs_d1 = 3'b000; cs_after = 3'b111; busy_after = 1'b0;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if ((d1 != 0) && (c == d1 + 1)) begin
                busy_after = busy;
                cs_after   = CS;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    d1    = c;
                    cs_d1 = CS;
                end else begin
                    d2 = c;
                    break;
                end
            end
        end
        start = 1'b0;
        check_eq("hold_d1", 32'(d1), 32'd35);
        check_eq("hold_cs_done", 32'(cs_d1), 32'h7);
        check_eq("hold_busy_next", 32'(busy_after), 32'h1);
        check_eq("hold_cs_next", 32'(cs_after), 32'h6);
        check_eq("hold_d2", 32'(d2), 32'd70);
        check_eq("hold_rx", 32'(masterDataReceived), 32'h33);

        // Reset in cycle 10 of a transfer.
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b1;
        masterDataToSend = 8'h96; slaveSelect = 2'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("mrst_cs", 32'(CS), 32'h7);
        check_eq("mrst_sclk", 32'(SCLK), 32'h0);
        check_eq("mrst_busy", 32'(busy), 32'h0);
        check_eq("mrst_rx", 32'(masterDataReceived), 32'h0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("mrst_no_done", 32'(ndone), 32'd0);
        do_xfer(1'b0, 1'b0, 1'b1, 8'hFF, 2'd0);
        check_eq("post_done_cyc", 32'(r_done_cyc), 32'd35);
        check_eq("post_rx", 32'(r_rx), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised SPI master, successor to the team's fixed 8-bit, 3-slave, LSB-first master.
- Generates SCLK from the system clock with a programmable divider.
- Supports all four CPOL/CPHA modes, selectable bit order, and N chip selects.
- Fully synchronous, with a start/busy/done handshake to the host logic and a registered receive word.

Parameters:
- DATA_WIDTH, 8: bits per transfer (>=2).
- NUM_SLAVES, 3: number of chip-select lines (>=1).
- CLK_DIV, 2: SCLK half-period in clk cycles (>=1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  transfer request; sampled on each posedge.
- slaveSelect  input  max(1,$clog2(NUM_SLAVES))  target slave index.
- cpol  input  1  SCLK idle level; latched at accept.
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accept.
- lsb_first  input  1  1 = bit 0 is transferred first; latched at accept.
- masterDataToSend  input  DATA_WIDTH  transmit word; latched at accept.
- masterDataReceived  output  DATA_WIDTH  received word; registered.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse on a rejected request.
- SCLK  output  1  serial clock; registered, glitch-free.
- CS  output  NUM_SLAVES  active-low chip selects.
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high: it is sampled only at a posedge of clk, and polarity and synchronicity are fixed.
- Reset values: CS all 1, SCLK = 0, MOSI = 0, busy = 0, done = 0, err = 0, masterDataReceived = 0. The latched cpol/cpha/lsb_first are cleared, and the FSM goes to IDLE.
- Reset mid-transfer: abort immediately. Outputs take reset values at that edge; no done pulse is issued.
- FSM states: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
- IDLE:
  - SCLK = latched cpol and CS all 1.
  - Accept: start = 1 in IDLE at cycle 0.
    - If slaveSelect < NUM_SLAVES: latch all inputs, then go to LEAD.
    - Otherwise: pulse err at cycle 1, with no CS assertion and no busy.
  - start while not IDLE is ignored (no queueing, no err).
- Cycle 1 (entry to LEAD):
  - busy = 1.
  - CS[slaveSelect] = 0; all other CS bits stay 1.
  - SCLK = cpol.
  - If cpha = 0, MOSI = first bit.
- Timing, with D = CLK_DIV and W = DATA_WIDTH:
  - SCLK edge k (k = 1..2W) toggles at cycle 1 + k*D.
  - Odd k is the leading edge; even k is the trailing edge.
  - After edge 2W, SCLK rests at cpol.
- Data phases:
  - cpha = 0: sample MISO on leading edges; drive the next MOSI bit on trailing edges 2..2W-2.
  - cpha = 1: drive a MOSI bit on each leading edge; sample MISO on trailing edges.
  - "Sample" means MISO is captured at the same clk posedge that toggles SCLK.
- Bit order:
  - lsb_first = 1: transmit tx[0] first; received bits are shifted in from the MSB end, so the first received bit ends at rx[0].
  - lsb_first = 0: transmit tx[W-1] first; the first received bit ends at rx[W-1].
- TRAIL: hold CS low for D cycles after the last edge.
- Cycle 1 + (2W+1)*D:
  - CS all 1; busy = 0; done = 1 for one cycle.
  - masterDataReceived updates in the same cycle and holds until the next done or reset.
  - MOSI returns to 0.
- Back-to-back: a new start may be accepted in the done cycle (FSM is in IDLE). CS then stays high for at least one cycle.
- Counters: divider counter is $clog2(D+1) bits; edge counter is $clog2(2W+1) bits. No wrap occurs within a transfer.

Test Plan:
- Loopback MOSI->MISO, mode 0, lsb_first = 1, tx = 0xA5, slaveSelect = 1 -> CS = 3'b101 during transfer, done at cycle 35 (W = 8, D = 2), rx = 0xA5, SCLK shows 8 rising edges starting at cycle 3.
- Slave model shifting out 0x3C MSB-first in mode 3, with lsb_first = 0 and tx = 0x81 -> SCLK idles 1, slave captures 0x81, rx = 0x3C, SCLK returns to 1 after the last edge.
- Modes 1 and 2 with loopback, tx = 0x5A -> rx = 0x5A. Verify MOSI changes only on the edge opposite the sampling edge.
- slaveSelect = 3 with NUM_SLAVES = 3 -> err pulses at cycle 1, CS stays 3'b111, busy stays 0, no done.
- start held high throughout a transfer -> only one transfer runs; the next is accepted in the done cycle, and CS is high for at least one cycle between transfers.
- reset asserted at cycle 10 of a transfer -> at the next posedge: CS = 3'b111, SCLK = 0, busy = 0, rx = 0, no done pulse; a subsequent transfer with tx = 0xFF completes normally.
